// File: rtl/dpb_frame_writer_50m.sv
// Packs 128-bit UDP payload beats into a 4-slot x 256-word x 64-bit BRAM ring.
// Each packet's data lands in words 2..255 of its slot; the header goes to word 0 once all data is written.
module dpb_frame_writer_50m (
    input  logic         i_clk50m,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic [127:0] i_data,
    input  logic         i_pkt_last,
    input  logic         i_jpeg_last,
    input  logic [4:0]   i_last_bytes,
    input  logic [14:0]  i_frame_rank,
    input  logic [1:0]   i_rd_slot,
    output logic         o_ready,
    output logic [1:0]   o_buf_rank,
    output logic         o_overflow,
    output logic         o_dpb_wr_a_clk,
    output logic         o_dpb_wr_a_cea,
    output logic         o_dpb_wr_a_ocea,
    output logic         o_dpb_wr_a_rst,
    output logic         o_dpb_wr_a_wr_en,
    output logic [9:0]   o_dpb_wr_a_addr,
    output logic [63:0]  o_dpb_wr_a_wr_data,
    input  logic [63:0]  o_dpb_wr_a_rd_data
);

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned WORD_W   = 64;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned SLOT_W   = 2;
    localparam int unsigned BEAT_W   = 7;
    localparam int unsigned RANK_W   = 15;
    localparam int unsigned BYTES_W  = 5;
    localparam int unsigned SIGN_W   = 32;
    localparam int unsigned MAX_BEAT = 127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_HDR,
        ST_ADV
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SIGN_W-1:0]   sign_q, sign_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                jpeg_q, jpeg_d;
    logic [BYTES_W-1:0]  bytes_q, bytes_d;
    logic [RANK_W-1:0]   rank_q, rank_d;
    logic                lo_wr_q, lo_wr_d;
    logic                ready_q, ready_d;
    logic                ov_q, ov_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;

    logic                accept;
    logic                close_pkt;
    logic                jpeg_eff;
    logic [WORD_W-1:0]   header;
    logic                unused_rd_data;

    assign accept    = i_valid & ready_q;
    assign close_pkt = last_q | (beat_q == BEAT_W'(MAX_BEAT));
    assign jpeg_eff  = last_q & jpeg_q;
    assign header    = {jpeg_eff, rank_q, 8'(beat_q),
                        jpeg_eff ? 8'(bytes_q) : 8'd0, sign_q};

    // Read port is not used by the writer.
    assign unused_rd_data = ^o_dpb_wr_a_rd_data;

    always_ff @(posedge i_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            sign_q    <= '0;
            beat_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            jpeg_q    <= 1'b0;
            bytes_q   <= '0;
            rank_q    <= '0;
            lo_wr_q   <= 1'b0;
            ready_q   <= 1'b0;
            ov_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            sign_q    <= sign_d;
            beat_q    <= beat_d;
            data_q    <= data_d;
            last_q    <= last_d;
            jpeg_q    <= jpeg_d;
            bytes_q   <= bytes_d;
            rank_q    <= rank_d;
            lo_wr_q   <= lo_wr_d;
            ready_q   <= ready_d;
            ov_q      <= ov_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        sign_d    = sign_q;
        beat_d    = beat_q;
        data_d    = data_q;
        last_d    = last_q;
        jpeg_d    = jpeg_q;
        bytes_d   = bytes_q;
        rank_d    = rank_q;
        lo_wr_d   = 1'b0;
        ready_d   = 1'b0;
        ov_d      = 1'b0;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = i_data;
                    last_d  = i_pkt_last;
                    jpeg_d  = i_jpeg_last;
                    bytes_d = i_last_bytes;
                    rank_d  = i_frame_rank;
                    beat_d  = BEAT_W'(1);
                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                wr_en_d   = 1'b1;
                addr_d    = {slot_q, beat_q, 1'b0};
                wr_data_d = data_q[DATA_W-1:WORD_W];
                lo_wr_d   = 1'b1;
                state_d   = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                // Low word is written once; later cycles here just wait for the next beat.
                if (lo_wr_q) begin
                    wr_en_d   = 1'b1;
                    addr_d    = {slot_q, beat_q, 1'b1};
                    wr_data_d = data_q[WORD_W-1:0];
                end
                if (close_pkt) begin
                    state_d = ST_HDR;
                end else if (accept) begin
                    data_d  = i_data;
                    last_d  = i_pkt_last;
                    jpeg_d  = i_jpeg_last;
                    bytes_d = i_last_bytes;
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = ST_DATA_HI;
                end
            end
            ST_HDR: begin
                wr_en_d   = 1'b1;
                addr_d    = {slot_q, 8'd0};
                wr_data_d = header;
                state_d   = ST_ADV;
            end
            ST_ADV: begin
                slot_d  = slot_q + SLOT_W'(1);
                sign_d  = sign_q + SIGN_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready is registered, so it is derived from the state being entered.
        case (state_d)
            ST_IDLE:    ready_d = ((slot_d + SLOT_W'(1)) != i_rd_slot);
            ST_DATA_LO: ready_d = ~(last_d | (beat_d == BEAT_W'(MAX_BEAT)));
            default:    ready_d = 1'b0;
        endcase

        ov_d = (state_d == ST_HDR) && (state_q == ST_DATA_LO) && !last_q;
    end

    assign o_ready            = ready_q;
    assign o_buf_rank         = slot_q;
    assign o_overflow         = ov_q;
    assign o_dpb_wr_a_clk     = i_clk50m;
    assign o_dpb_wr_a_cea     = 1'b1;
    assign o_dpb_wr_a_ocea    = 1'b1;
    assign o_dpb_wr_a_rst     = ~i_rst_n;
    assign o_dpb_wr_a_wr_en   = wr_en_q;
    assign o_dpb_wr_a_addr    = addr_q;
    assign o_dpb_wr_a_wr_data = wr_data_q;

endmodule

// File: tb/tb_dpb_frame_writer_50m.sv
// Bench for dpb_frame_writer_50m: randomized packets checked against a packet-level
// write-sequence model, plus literal expectations for the documented scenarios.
module tb_dpb_frame_writer_50m;

    logic         i_clk50m = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic [127:0] i_data;
    logic         i_pkt_last;
    logic         i_jpeg_last;
    logic [4:0]   i_last_bytes;
    logic [14:0]  i_frame_rank;
    logic [1:0]   i_rd_slot;
    logic         o_ready;
    logic [1:0]   o_buf_rank;
    logic         o_overflow;
    logic         wr_clk, wr_cea, wr_ocea, wr_rst, wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [63:0]  rd_data;

    always #10 i_clk50m = ~i_clk50m;

    dpb_frame_writer_50m dut (
        .i_clk50m           (i_clk50m),
        .i_rst_n            (i_rst_n),
        .i_valid            (i_valid),
        .i_data             (i_data),
        .i_pkt_last         (i_pkt_last),
        .i_jpeg_last        (i_jpeg_last),
        .i_last_bytes       (i_last_bytes),
        .i_frame_rank       (i_frame_rank),
        .i_rd_slot          (i_rd_slot),
        .o_ready            (o_ready),
        .o_buf_rank         (o_buf_rank),
        .o_overflow         (o_overflow),
        .o_dpb_wr_a_clk     (wr_clk),
        .o_dpb_wr_a_cea     (wr_cea),
        .o_dpb_wr_a_ocea    (wr_ocea),
        .o_dpb_wr_a_rst     (wr_rst),
        .o_dpb_wr_a_wr_en   (wr_en),
        .o_dpb_wr_a_addr    (wr_addr),
        .o_dpb_wr_a_wr_data (wr_data),
        .o_dpb_wr_a_rd_data (rd_data)
    );

    int checks = 0;
    int failures = 0;

    // Model: expected BRAM write stream plus packet bookkeeping.
    logic [9:0]  exp_addr[$];
    logic [63:0] exp_data[$];
    int          m_slot = 0;
    int          m_beat = 0;
    logic [31:0] m_sign = '0;
    logic [14:0] m_rank = '0;
    int          exp_ov = 0;

    // Observations.
    logic [63:0] mem [0:1023];
    int          cyc = 0;
    int          wr_cyc[$];
    logic [31:0] hdr_sign[$];
    logic [1:0]  rank_seq[$];
    logic [1:0]  prev_rank = '0;
    int          ov_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Compare process: every DUT write is checked against the model's stream.
    always @(negedge i_clk50m) begin
        cyc++;
        if (i_rst_n) begin
            if (o_overflow) ov_count++;
            if (o_buf_rank != prev_rank) rank_seq.push_back(o_buf_rank);
            prev_rank = o_buf_rank;
            if (wr_en) begin
                mem[wr_addr] = wr_data;
                wr_cyc.push_back(cyc);
                if (wr_addr[7:0] == 8'd0) hdr_sign.push_back(wr_data[31:0]);
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h expected=none", wr_addr, wr_data);
                end else begin
                    check("wr_addr", 64'(wr_addr), 64'(exp_addr.pop_front()));
                    check("wr_data", wr_data, exp_data.pop_front());
                end
            end
        end else begin
            prev_rank = '0;
        end
    end

    task automatic model_beat(input logic [127:0] d, input bit last, input bit jl,
                              input logic [4:0] lb, input logic [14:0] rk);
        bit          jle;
        logic [63:0] h;
        if (m_beat == 0) m_rank = rk;
        m_beat++;
        exp_addr.push_back({2'(m_slot), 7'(m_beat), 1'b0});
        exp_data.push_back(d[127:64]);
        exp_addr.push_back({2'(m_slot), 7'(m_beat), 1'b1});
        exp_data.push_back(d[63:0]);
        if (last || m_beat == 127) begin
            jle = last & jl;
            h = {jle, m_rank, 8'(m_beat), jle ? {3'b000, lb} : 8'h00, m_sign};
            exp_addr.push_back({2'(m_slot), 8'd0});
            exp_data.push_back(h);
            if (!last) exp_ov++;
            m_slot = (m_slot + 1) % 4;
            m_sign = m_sign + 32'd1;
            m_beat = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_beat(input logic [127:0] d, input bit last, input bit jl,
                             input logic [4:0] lb, input logic [14:0] rk, input int gap);
        int n;
        i_rd_slot = 2'((m_slot + 3) % 4);
        model_beat(d, last, jl, lb, rk);
        i_valid = 1'b0;
        repeat (gap) @(negedge i_clk50m);
        i_valid      = 1'b1;
        i_data       = d;
        i_pkt_last   = last;
        i_jpeg_last  = jl;
        i_last_bytes = lb;
        i_frame_rank = rk;
        n = 0;
        while (!o_ready && n < 500) begin
            @(negedge i_clk50m);
            n++;
        end
        if (!o_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=ready_low expected=ready_high");
        end else begin
            @(posedge i_clk50m);
            @(negedge i_clk50m);
        end
        i_valid = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send_pkt(input int nbeats, input bit jl, input int gapmax);
        for (int i = 1; i <= nbeats; i++)
            send_beat(rnd128(), i == nbeats, jl, 5'($urandom_range(1, 16)),
                      15'($urandom()), $urandom_range(0, gapmax));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_addr.size() != 0 && n < 400) begin
            @(negedge i_clk50m);
            n++;
        end
        checks++;
        if (exp_addr.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_addr.size());
        end
        repeat (3) @(negedge i_clk50m);
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        m_slot = 0;
        m_beat = 0;
        m_sign = '0;
        repeat (2) @(negedge i_clk50m);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_addr", 64'(wr_addr), 64'd0);
        check("rst_data", wr_data, 64'd0);
        check("rst_buf_rank", 64'(o_buf_rank), 64'd0);
        check("rst_overflow", 64'(o_overflow), 64'd0);
        check("rst_bram_rst", 64'(wr_rst), 64'd1);
        i_rst_n = 1'b1;
        @(negedge i_clk50m);
    endtask

    initial begin
        int s;
        int ov0;
        i_rst_n      = 1'b0;
        i_valid      = 1'b0;
        i_data       = '0;
        i_pkt_last   = 1'b0;
        i_jpeg_last  = 1'b0;
        i_last_bytes = 5'd1;
        i_frame_rank = '0;
        i_rd_slot    = 2'd1;
        rd_data      = '0;
        @(negedge i_clk50m);
        check("bram_cea", 64'(wr_cea), 64'd1);
        check("bram_ocea", 64'(wr_ocea), 64'd1);
        apply_reset();

        // Consumer on slot 1 blocks the writer at slot 0 until it moves on.
        for (int k = 0; k < 5; k++) begin
            check("ready_blocked", 64'(o_ready), 64'd0);
            @(negedge i_clk50m);
        end
        i_rd_slot = 2'd2;
        @(negedge i_clk50m);
        check("ready_after_rdslot", 64'(o_ready), 64'd1);

        // Single-beat JPEG-final packet.
        send_beat(128'h0123456789abcdef_fedcba9876543210, 1'b1, 1'b1, 5'd5, 15'h0012, 0);
        wait_drain();
        check("single_hi", mem[2], 64'h0123456789abcdef);
        check("single_lo", mem[3], 64'hfedcba9876543210);
        check("single_hdr", mem[0], 64'h8012_0105_0000_0000);
        check("single_rank", 64'(o_buf_rank), 64'd1);

        // Three beats back-to-back: data writes on consecutive cycles.
        s = wr_cyc.size();
        send_beat(rnd128(), 1'b0, 1'b0, 5'd3, 15'h0034, 0);
        send_beat(rnd128(), 1'b0, 1'b0, 5'd7, 15'h1111, 0);
        send_beat(rnd128(), 1'b1, 1'b0, 5'd9, 15'h2222, 0);
        wait_drain();
        for (int k = 1; k < 6; k++)
            check("consecutive_wr", 64'(wr_cyc[s+k] - wr_cyc[s+k-1]), 64'd1);
        check("three_hdr", mem[256], 64'h0034_0300_0000_0001);

        // 128 beats without an early last: forced close at 127.
        ov0 = ov_count;
        send_pkt(128, 1'b1, 0);
        wait_drain();
        check("ovf_pulses", 64'(ov_count - ov0), 64'd1);
        check("ovf_hdr_fields", 64'(mem[512][63:32]), 64'(32'h0000_7f00) | 64'(mem[512][62:48]) << 16);
        check("ovf_jpeg_bit", 64'(mem[512][63]), 64'd0);
        check("ovf_next_count", 64'(mem[768][47:40]), 64'd1);
        check("ovf_buf_rank", 64'(o_buf_rank), 64'd0);

        // Reset while waiting in the low-word state of beat 2.
        send_beat(rnd128(), 1'b0, 1'b0, 5'd1, 15'h0055, 0);
        send_beat(rnd128(), 1'b0, 1'b0, 5'd1, 15'h0055, 0);
        repeat (3) @(negedge i_clk50m);
        check("pre_reset_pending", 64'(exp_addr.size()), 64'd0);
        mem[0] = 64'hdead_beef_dead_beef;
        apply_reset();
        send_beat(rnd128(), 1'b1, 1'b1, 5'd16, 15'h0777, 0);
        wait_drain();
        check("post_reset_sign", 64'(mem[0][31:0]), 64'd0);
        check("post_reset_bytes", 64'(mem[0][39:32]), 64'h10);
        check("post_reset_rank", 64'(o_buf_rank), 64'd1);

        // Five back-to-back packets from a fresh reset.
        apply_reset();
        hdr_sign.delete();
        rank_seq.delete();
        for (int p = 0; p < 5; p++) send_pkt($urandom_range(1, 4), $urandom_range(0, 1), 0);
        wait_drain();
        check("b2b_hdr_count", 64'(hdr_sign.size()), 64'd5);
        check("b2b_rank_count", 64'(rank_seq.size()), 64'd5);
        if (hdr_sign.size() == 5 && rank_seq.size() == 5) begin
            for (int p = 0; p < 5; p++) begin
                check("b2b_sign", 64'(hdr_sign[p]), 64'(p));
                check("b2b_rank", 64'(rank_seq[p]), 64'((p + 1) % 4));
            end
        end

        // Randomized traffic with gaps.
        for (int p = 0; p < 40; p++)
            send_pkt(($urandom_range(0, 19) == 0) ? $urandom_range(126, 130) : $urandom_range(1, 12),
                     $urandom_range(0, 1), 3);
        wait_drain();
        check("ovf_total", 64'(ov_count), 64'(exp_ov));
        check("final_rank", 64'(o_buf_rank), 64'(m_slot));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
